// File: rtl/seq_divider.sv
// Multi-cycle radix-2 restoring divider, signed or unsigned, fixed latency.
// Ports: clk, rst (sync, active-high), start, signed_op, dividend, divisor,
//   busy, done (1-cycle pulse), quotient, remainder, div_by_zero.
module seq_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIXUP,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dq_q, dq_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] orig_q, orig_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rmd_q, rmd_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   trial;
  logic             accept;
  logic             a_neg;
  logic             b_neg;

  // dq_q starts as the dividend magnitude and shifts left each RUN cycle;
  // its MSB feeds the partial remainder and quotient bits enter at the LSB,
  // so after WIDTH cycles it holds the unsigned quotient.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dq_d    = dq_q;
    dvs_d   = dvs_q;
    orig_d  = orig_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dbz_d   = dbz_q;
    accept  = 1'b0;
    a_neg   = signed_op & dividend[WIDTH-1];
    b_neg   = signed_op & divisor[WIDTH-1];
    // Partial remainder is always below the divisor, so the MSB of this
    // WIDTH+1 bit difference is a reliable borrow/sign bit.
    trial   = {rem_q, dq_q[WIDTH-1]} - {1'b0, dvs_q};

    unique case (state_q)
      S_IDLE: begin
        if (start) accept = 1'b1;
      end
      S_RUN: begin
        if (!trial[WIDTH]) begin
          rem_d = trial[WIDTH-1:0];
          dq_d  = {dq_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = {rem_q[WIDTH-2:0], dq_q[WIDTH-1]};
          dq_d  = {dq_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = S_FIXUP;
      end
      S_FIXUP: begin
        // A zero divisor has zero magnitude, so dvs_q detects it directly.
        if (dvs_q == '0) begin
          quo_d = '1;
          rmd_d = orig_q;
          dbz_d = 1'b1;
        end else begin
          quo_d = qneg_q ? -dq_q : dq_q;
          rmd_d = rneg_q ? -rem_q : rem_q;
          dbz_d = 1'b0;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        if (start) accept = 1'b1;
        else       state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      dq_d    = a_neg ? -dividend : dividend;
      dvs_d   = b_neg ? -divisor : divisor;
      orig_d  = dividend;
      qneg_d  = a_neg ^ b_neg;
      rneg_d  = a_neg;
      rem_d   = '0;
      cnt_d   = CNT_W'(WIDTH);
      state_d = S_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dq_q    <= '0;
      dvs_q   <= '0;
      orig_q  <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dq_q    <= dq_d;
      dvs_q   <= dvs_d;
      orig_q  <= orig_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q == S_RUN) || (state_q == S_FIXUP);
  assign done        = (state_q == S_DONE);
  assign quotient    = quo_q;
  assign remainder   = rmd_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: arithmetic reference model, per-cycle compare,
// directed literal cases and randomized traffic.
module tb_seq_divider;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         start;
  logic         signed_op;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  seq_divider #(.WIDTH(W), .CNT_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_op  (signed_op),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  // model state: t = cycles since acceptance (0 = idle), W+2 = done cycle
  int           m_t;
  logic [W-1:0] m_q, m_r, p_q, p_r;
  logic         m_z, p_z;
  logic         armed;

  // literal expectation slot, checked by the compare process
  logic         lit_on;
  string        lit_tag;
  logic         lit_busy, lit_done, lit_z;
  logic [W-1:0] lit_q, lit_r;

  task automatic ref_div(input logic s, input logic [W-1:0] a,
                         input logic [W-1:0] b, output logic [W-1:0] q,
                         output logic [W-1:0] r, output logic z);
    longint sa, sb, lq, lr;
    if (b == '0) begin
      q = '1;
      r = a;
      z = 1'b1;
    end else begin
      sa = s ? longint'($signed(a)) : longint'(a);
      sb = s ? longint'($signed(b)) : longint'(b);
      lq = sa / sb;
      lr = sa % sb;
      q  = lq[W-1:0];
      r  = lr[W-1:0];
      z  = 1'b0;
    end
  endtask

  initial begin
    m_t = 0;
    m_q = '0;
    m_r = '0;
    m_z = 1'b0;
    p_q = '0;
    p_r = '0;
    p_z = 1'b0;
    armed = 1'b0;
  end

  always @(posedge clk) begin
    if (rst) begin
      m_t = 0;
      m_q = '0;
      m_r = '0;
      m_z = 1'b0;
      armed = 1'b1;
    end else if (m_t != 0 && m_t != W + 2) begin
      m_t = m_t + 1;
      if (m_t == W + 2) begin
        m_q = p_q;
        m_r = p_r;
        m_z = p_z;
      end
    end else if (start) begin
      ref_div(signed_op, dividend, divisor, p_q, p_r, p_z);
      m_t = 1;
    end else begin
      m_t = 0;
    end
  end

  task automatic cmp(input string name, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    n_chk = n_chk + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      cmp("busy", W'(busy), W'(m_t >= 1 && m_t <= W + 1));
      cmp("done", W'(done), W'(m_t == W + 2));
      cmp("quotient", quotient, m_q);
      cmp("remainder", remainder, m_r);
      cmp("div_by_zero", W'(div_by_zero), W'(m_z));
    end
    if (lit_on) begin
      cmp({lit_tag, ".busy"}, W'(busy), W'(lit_busy));
      cmp({lit_tag, ".done"}, W'(done), W'(lit_done));
      cmp({lit_tag, ".q"}, quotient, lit_q);
      cmp({lit_tag, ".r"}, remainder, lit_r);
      cmp({lit_tag, ".dbz"}, W'(div_by_zero), W'(lit_z));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic lit(input string tag, input logic b, input logic d,
                     input logic [W-1:0] q, input logic [W-1:0] r,
                     input logic z);
    lit_tag  = tag;
    lit_busy = b;
    lit_done = d;
    lit_q    = q;
    lit_r    = r;
    lit_z    = z;
    lit_on   = 1'b1;
    @(negedge clk);
    #1;
    lit_on   = 1'b0;
  endtask

  task automatic go(input logic s, input logic [W-1:0] a,
                    input logic [W-1:0] b);
    start     = 1'b1;
    signed_op = s;
    dividend  = a;
    divisor   = b;
    tick(1);
    start     = 1'b0;
  endtask

  task automatic run_dir(input string tag, input logic s,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic ez);
    go(s, a, b);
    tick(W + 1);
    lit(tag, 1'b0, 1'b1, eq, er, ez);
    tick(1);
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] v;
    case ($urandom_range(0, 7))
      0: v = '0;
      1: v = 32'h8000_0000;
      2: v = 32'hFFFF_FFFF;
      3: v = W'($urandom_range(0, 15));
      4: v = -W'($urandom_range(1, 15));
      default: v = W'($urandom());
    endcase
    return v;
  endfunction

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    lit_on    = 1'b0;
    lit_tag   = "";
    lit_busy  = 1'b0;
    lit_done  = 1'b0;
    lit_q     = '0;
    lit_r     = '0;
    lit_z     = 1'b0;
    rst       = 1'b1;
    start     = 1'b0;
    signed_op = 1'b0;
    dividend  = '0;
    divisor   = '0;
    tick(3);
    rst = 1'b0;
    lit("reset", 1'b0, 1'b0, '0, '0, 1'b0);
    tick(1);

    // 100/7 with latency checks: busy through cycle 33, done at 34
    go(1'b0, 32'd100, 32'd7);
    lit("lat_c1", 1'b1, 1'b0, '0, '0, 1'b0);
    tick(W);
    lit("lat_c33", 1'b1, 1'b0, '0, '0, 1'b0);
    tick(1);
    lit("u100_7", 1'b0, 1'b1, 32'd14, 32'd2, 1'b0);
    tick(1);

    run_dir("sneg100_7", 1'b1, 32'hFFFF_FF9C, 32'd7,
            32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
    run_dir("s100_neg7", 1'b1, 32'd100, 32'hFFFF_FFF9,
            32'hFFFF_FFF2, 32'd2, 1'b0);
    run_dir("u_dbz", 1'b0, 32'h1234_5678, 32'd0,
            32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
    run_dir("s_dbz", 1'b1, 32'h1234_5678, 32'd0,
            32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
    run_dir("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
            32'h8000_0000, 32'd0, 1'b0);
    run_dir("u5_10", 1'b0, 32'd5, 32'd10, 32'd0, 32'd5, 1'b0);
    run_dir("umax_1", 1'b0, 32'hFFFF_FFFF, 32'd1,
            32'hFFFF_FFFF, 32'd0, 1'b0);
    run_dir("umax_big", 1'b0, 32'hFFFF_FFFF, 32'h8000_0001,
            32'd1, 32'h7FFF_FFFE, 1'b0);

    // start while busy is ignored; start in done cycle is accepted
    go(1'b0, 32'd9, 32'd2);
    tick(9);
    start    = 1'b1;
    dividend = 32'd50;
    divisor  = 32'd5;
    tick(1);
    start = 1'b0;
    tick(23);
    lit("hs_9_2", 1'b0, 1'b1, 32'd4, 32'd1, 1'b0);
    start     = 1'b1;
    signed_op = 1'b0;
    dividend  = 32'd50;
    divisor   = 32'd5;
    tick(1);
    start = 1'b0;
    tick(15);
    lit("hs_hold", 1'b1, 1'b0, 32'd4, 32'd1, 1'b0);
    tick(18);
    lit("hs_50_5", 1'b0, 1'b1, 32'd10, 32'd0, 1'b0);
    tick(1);

    // reset mid-operation
    go(1'b0, 32'd1000, 32'd3);
    tick(9);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    lit("rst_abort", 1'b0, 1'b0, '0, '0, 1'b0);
    tick(1);
    go(1'b0, 32'd1000, 32'd3);
    tick(W + 1);
    lit("rst_redo", 1'b0, 1'b1, 32'd333, 32'd1, 1'b0);
    tick(1);

    // random traffic: starts at any time, operands change every cycle
    for (int c = 0; c < 2500; c++) begin
      rst       = ($urandom_range(0, 599) == 0);
      start     = ($urandom_range(0, 3) == 0);
      signed_op = 1'($urandom_range(0, 1));
      dividend  = pick();
      divisor   = pick();
      tick(1);
    end
    rst   = 1'b0;
    start = 1'b0;
    tick(W + 4);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
